// File: rtl/pong_render.sv
// pong_render -- VGA-style raster generator that draws a Pong court.
//
// A horizontal/vertical raster counter pair sweeps the screen. Each pixel is
// mapped to a game cell (2^SCALE_SHIFT pixels per cell in both axes) and lit
// when it falls on the ball, on either paddle or, optionally, on the court
// decoration. Game positions are snapshotted once per frame, at the first
// blanked line, so that a frame is always drawn from one consistent state.
//
// Parameters
//   PADDLE_HALF            paddle half-height in cells (span = centre +/- PADDLE_HALF)
//   SCALE_SHIFT            log2 of pixels per game cell
//   H_* / V_*              raster timing; defaults give the 640x480 @ 800x525 mode
//
// Ports
//   clk             in   pixel clock, rising edge
//   reset           in   synchronous active-high reset
//   ball_x, ball_y  in   ball cell position
//   left_paddle_y   in   left paddle centre row (drawn in cell column 1)
//   right_paddle_y  in   right paddle centre row (drawn two columns from the right)
//   hsync, vsync    out  active-low sync pulses
//   active          out  pixel is inside the visible area
//   pixel_on        out  visible pixel is lit
//   frame_tick      out  one-cycle pulse per frame for the game logic
//
// All outputs are registered and describe the raster position of the previous
// cycle. Optional macro PONG_RENDER_NET_EN adds the top/bottom walls and the
// dashed centre net.
module pong_render #(
   parameter int PADDLE_HALF  = 4,
   parameter int SCALE_SHIFT  = 2,
   parameter int H_VISIBLE    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_END   = 751,
   parameter int H_TOTAL      = 800,
   parameter int V_VISIBLE    = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_END   = 491,
   parameter int V_TOTAL      = 525
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ball_x,
   input  logic [7:0] ball_y,
   input  logic [7:0] left_paddle_y,
   input  logic [7:0] right_paddle_y,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic       pixel_on,
   output logic       frame_tick
);

   localparam int HC_W      = $clog2(H_TOTAL);
   localparam int VC_W      = $clog2(V_TOTAL);
   localparam int LEFT_COL  = 1;
   localparam int RIGHT_COL = (H_VISIBLE >> SCALE_SHIFT) - 2;

   logic [HC_W-1:0] hc_r;
   logic [VC_W-1:0] vc_r;
   logic [7:0]      snap_bx_r;
   logic [7:0]      snap_by_r;
   logic [7:0]      snap_lp_r;
   logic [7:0]      snap_rp_r;

   logic [15:0]       gx_s;
   logic [15:0]       gy_s;
   logic              gy_small_s;
   logic signed [8:0] left_diff_s;
   logic signed [8:0] right_diff_s;
   logic              active_s;
   logic              ball_hit_s;
   logic              left_hit_s;
   logic              right_hit_s;
   logic              draw_s;
   logic              pixel_s;
   logic              hsync_s;
   logic              vsync_s;
   logic              capture_s;

   // True when a signed cell distance lies within the paddle span.
   function automatic logic in_span(input logic signed [8:0] d);
      return (int'(d) >= -PADDLE_HALF) && (int'(d) <= PADDLE_HALF);
   endfunction

   // Pixel classification for the current raster position.
   always_comb begin
      gx_s       = 16'(hc_r >> SCALE_SHIFT);
      gy_s       = 16'(vc_r >> SCALE_SHIFT);
      gy_small_s = (gy_s[15:8] == 8'd0);
      // 9-bit signed differences: a centre near 0 must not wrap onto the bottom rows.
      left_diff_s  = $signed({1'b0, gy_s[7:0]}) - $signed({1'b0, snap_lp_r});
      right_diff_s = $signed({1'b0, gy_s[7:0]}) - $signed({1'b0, snap_rp_r});
      active_s    = (hc_r < HC_W'(H_VISIBLE)) && (vc_r < VC_W'(V_VISIBLE));
      // Full-width compares so an out-of-range position never aliases into view.
      ball_hit_s  = (gx_s == {8'd0, snap_bx_r}) && (gy_s == {8'd0, snap_by_r});
      left_hit_s  = (gx_s == 16'(LEFT_COL)) && gy_small_s && in_span(left_diff_s);
      right_hit_s = (gx_s == 16'(RIGHT_COL)) && gy_small_s && in_span(right_diff_s);
`ifdef PONG_RENDER_NET_EN
      draw_s = ball_hit_s || left_hit_s || right_hit_s ||
               (gy_s == 16'd0) ||
               (gy_s == 16'((V_VISIBLE >> SCALE_SHIFT) - 1)) ||
               ((gx_s == 16'(((H_VISIBLE >> SCALE_SHIFT) / 2) - 1)) && (gy_s[0] == 1'b0));
`else
      draw_s = ball_hit_s || left_hit_s || right_hit_s;
`endif
      pixel_s   = active_s && draw_s;
      hsync_s   = !((hc_r >= HC_W'(H_SYNC_START)) && (hc_r <= HC_W'(H_SYNC_END)));
      vsync_s   = !((vc_r >= VC_W'(V_SYNC_START)) && (vc_r <= VC_W'(V_SYNC_END)));
      capture_s = (hc_r == {HC_W{1'b0}}) && (vc_r == VC_W'(V_VISIBLE));
   end

   // Raster counters, per-frame position snapshot and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         hc_r       <= {HC_W{1'b0}};
         vc_r       <= {VC_W{1'b0}};
         snap_bx_r  <= 8'd0;
         snap_by_r  <= 8'd0;
         snap_lp_r  <= 8'd0;
         snap_rp_r  <= 8'd0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         active     <= 1'b0;
         pixel_on   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         if (hc_r == HC_W'(H_TOTAL - 1)) begin
            hc_r <= {HC_W{1'b0}};
            if (vc_r == VC_W'(V_TOTAL - 1)) begin
               vc_r <= {VC_W{1'b0}};
            end else begin
               vc_r <= vc_r + VC_W'(1);
            end
         end else begin
            hc_r <= hc_r + HC_W'(1);
         end
         if (capture_s) begin
            snap_bx_r <= ball_x;
            snap_by_r <= ball_y;
            snap_lp_r <= left_paddle_y;
            snap_rp_r <= right_paddle_y;
         end else begin
            snap_bx_r <= snap_bx_r;
            snap_by_r <= snap_by_r;
            snap_lp_r <= snap_lp_r;
            snap_rp_r <= snap_rp_r;
         end
         hsync      <= hsync_s;
         vsync      <= vsync_s;
         active     <= active_s;
         pixel_on   <= pixel_s;
         frame_tick <= capture_s;
      end
   end

endmodule

// File: tb/tb_pong_render.sv
// Self-checking bench for pong_render. A compact raster timing is used so that
// several whole frames fit in a short run; the reference model derives every
// output from the absolute pixel index since reset using plain arithmetic.
module tb_pong_render;

   localparam int PH    = 4;
   localparam int S     = 2;
   localparam int H_VIS = 96;
   localparam int HS0   = 100;
   localparam int HS1   = 111;
   localparam int HT    = 120;
   localparam int V_VIS = 64;
   localparam int VS0   = 68;
   localparam int VS1   = 69;
   localparam int VT    = 72;
   localparam int FRAME = HT * VT;
   localparam int CAP   = V_VIS * HT;
   localparam int RCOL  = (H_VIS >> S) - 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ball_x;
   logic [7:0] ball_y;
   logic [7:0] left_paddle_y;
   logic [7:0] right_paddle_y;
   logic       hsync;
   logic       vsync;
   logic       active;
   logic       pixel_on;
   logic       frame_tick;

   int          checks = 0;
   int          errors = 0;
   int unsigned pos;
   int unsigned cur_p;
   logic [7:0]  m_bx, m_by, m_lp, m_rp;

   pong_render #(
      .PADDLE_HALF(PH), .SCALE_SHIFT(S),
      .H_VISIBLE(H_VIS), .H_SYNC_START(HS0), .H_SYNC_END(HS1), .H_TOTAL(HT),
      .V_VISIBLE(V_VIS), .V_SYNC_START(VS0), .V_SYNC_END(VS1), .V_TOTAL(VT)
   ) dut (
      .clk(clk), .reset(reset),
      .ball_x(ball_x), .ball_y(ball_y),
      .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
      .hsync(hsync), .vsync(vsync), .active(active),
      .pixel_on(pixel_on), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Expected {hsync, vsync, active, pixel_on, frame_tick} for pixel index p.
   function automatic logic [4:0] model_out(int unsigned p, logic [7:0] bx, logic [7:0] by,
                                            logic [7:0] lp, logic [7:0] rp);
      int   hc, vc, gx, gy, dl, dr;
      logic act, hs, vs, hit, tk;
      hc  = int'(p % HT);
      vc  = int'((p / HT) % VT);
      act = (hc < H_VIS) && (vc < V_VIS);
      hs  = !(hc >= HS0 && hc <= HS1);
      vs  = !(vc >= VS0 && vc <= VS1);
      gx  = hc / (1 << S);
      gy  = vc / (1 << S);
      dl  = gy - int'(lp);
      dr  = gy - int'(rp);
      if (dl < 0) dl = -dl;
      if (dr < 0) dr = -dr;
      hit = (gx == int'(bx) && gy == int'(by)) ||
            (gx == 1 && dl <= PH) || (gx == RCOL && dr <= PH);
`ifdef PONG_RENDER_NET_EN
      hit = hit || gy == 0 || gy == (V_VIS >> S) - 1 ||
            (gx == (H_VIS >> S) / 2 - 1 && gy % 2 == 0);
`endif
      tk  = (p % FRAME) == CAP;
      return {hs, vs, act, act && hit, tk};
   endfunction

   task automatic drive_random();
      ball_x         = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 27));
      ball_y         = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
      left_paddle_y  = 8'($urandom_range(0, 19));
      right_paddle_y = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
   endtask

   // Advance one clock, return observed and modelled outputs, update the model.
   task automatic step(output logic [4:0] obs, output logic [4:0] exp);
      @(posedge clk);
      #1;
      obs   = {hsync, vsync, active, pixel_on, frame_tick};
      exp   = model_out(pos, m_bx, m_by, m_lp, m_rp);
      cur_p = pos;
      if (pos % FRAME == CAP) begin
         m_bx = ball_x; m_by = ball_y; m_lp = left_paddle_y; m_rp = right_paddle_y;
      end
      pos++;
   endtask

   task automatic model_clear();
      pos = 0; m_bx = 8'd0; m_by = 8'd0; m_lp = 8'd0; m_rp = 8'd0;
   endtask

   task automatic test_reset();
      logic [4:0] o;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_random();
         @(posedge clk);
         #1;
         o = {hsync, vsync, active, pixel_on, frame_tick};
         checks++;
         if (o !== 5'b11000) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, o, 5'b11000);
         end
      end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_frames();
      logic [4:0] o, e;
      logic prev_hs = 1'b1, prev_vs = 1'b1;
      int hfall = -1, vfall = -1, ticks = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         drive_random();
         step(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            if (errors < 20) $display("FAIL frames_stream pos %0d: got %b expected %b", cur_p, o, e);
         end
         if (prev_hs && !o[4]) begin
            if (hfall >= 0) begin
               checks++;
               if (i - hfall != HT) begin
                  errors++;
                  if (errors < 20) $display("FAIL hsync_period: got %0d expected %0d", i - hfall, HT);
               end
            end
            hfall = i;
         end
         if (!prev_hs && o[4]) begin
            checks++;
            if (i - hfall != HS1 - HS0 + 1) begin
               errors++;
               if (errors < 20) $display("FAIL hsync_low: got %0d expected %0d", i - hfall, HS1 - HS0 + 1);
            end
         end
         if (prev_vs && !o[3]) begin
            if (vfall >= 0) begin
               checks++;
               if (i - vfall != FRAME) begin
                  errors++;
                  $display("FAIL vsync_period: got %0d expected %0d", i - vfall, FRAME);
               end
            end
            vfall = i;
         end
         if (!prev_vs && o[3]) begin
            checks++;
            if (i - vfall != (VS1 - VS0 + 1) * HT) begin
               errors++;
               $display("FAIL vsync_low: got %0d expected %0d", i - vfall, (VS1 - VS0 + 1) * HT);
            end
         end
         if (o[0] === 1'b1) ticks++;
         prev_hs = o[4];
         prev_vs = o[3];
      end
      checks++;
      if (ticks != 2) begin
         errors++;
         $display("FAIL frame_tick_count: got %0d expected %0d", ticks, 2);
      end
   endtask

   // Paddle near the top edge, ball overlapping it, right paddle clipped at the
   // bottom; ball_x is moved mid-frame and must not show until the next frame.
   task automatic test_paddle_edge();
      logic [4:0]  o, e;
      logic [15:0] lmask = 16'd0, rmask = 16'd0;
      int hc, vc, gx, gy, moved_cnt = 0;
      ball_x = 8'd1; ball_y = 8'd3; left_paddle_y = 8'd2; right_paddle_y = 8'd15;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            if (errors < 20) $display("FAIL paddle_stream pos %0d: got %b expected %b", cur_p, o, e);
         end
         hc = int'(cur_p % HT); vc = int'((cur_p / HT) % VT);
         gx = hc >> S; gy = vc >> S;
         if (i >= FRAME && o[2] === 1'b1 && o[1] === 1'b1) begin
            if (gx == 1) lmask[gy] = 1'b1;
            if (gx == RCOL) rmask[gy] = 1'b1;
            if (gx == 12 && gy == 3) moved_cnt++;
         end
         if (i == FRAME + 40 * HT) ball_x = 8'd12;
      end
      checks++;
      if (lmask !== 16'h007F) begin
         errors++;
         $display("FAIL left_paddle_rows: got %h expected %h", lmask, 16'h007F);
      end
      checks++;
      if (rmask !== 16'hF800) begin
         errors++;
         $display("FAIL right_paddle_rows: got %h expected %h", rmask, 16'hF800);
      end
      checks++;
      if (moved_cnt != 0) begin
         errors++;
         $display("FAIL midframe_current: got %0d expected %0d", moved_cnt, 0);
      end
   endtask

   task automatic test_midframe_next();
      logic [4:0] o, e;
      int hc, vc, cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         step(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            if (errors < 20) $display("FAIL next_frame_stream pos %0d: got %b expected %b", cur_p, o, e);
         end
         hc = int'(cur_p % HT); vc = int'((cur_p / HT) % VT);
         if (o[1] === 1'b1 && (hc >> S) == 12 && (vc >> S) == 3) cnt++;
      end
      checks++;
      if (cnt != (1 << S) * (1 << S)) begin
         errors++;
         $display("FAIL midframe_next: got %0d expected %0d", cnt, (1 << S) * (1 << S));
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0]  o, e;
      int unsigned target, tick_at = 0;
      int ticks = 0;
      target = pos + 30 * HT + 50;
      while (pos != target) begin
         drive_random();
         step(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            if (errors < 20) $display("FAIL pre_reset_stream pos %0d: got %b expected %b", cur_p, o, e);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_random();
         @(posedge clk);
         #1;
         o = {hsync, vsync, active, pixel_on, frame_tick};
         checks++;
         if (o !== 5'b11000) begin
            errors++;
            $display("FAIL mid_reset_outputs cycle %0d: got %b expected %b", i, o, 5'b11000);
         end
      end
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < CAP + HT; i++) begin
         drive_random();
         step(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            if (errors < 20) $display("FAIL post_reset_stream pos %0d: got %b expected %b", cur_p, o, e);
         end
         if (o[0] === 1'b1) begin
            ticks++;
            tick_at = cur_p;
         end
      end
      checks++;
      if (ticks != 1 || tick_at != CAP) begin
         errors++;
         $display("FAIL post_reset_tick: got %0d ticks at %0d expected 1 at %0d", ticks, tick_at, CAP);
      end
   endtask

   initial begin
      reset = 1'b1;
      ball_x = 8'd0; ball_y = 8'd0; left_paddle_y = 8'd0; right_paddle_y = 8'd0;
      model_clear();
      test_reset();
      test_frames();
      test_paddle_edge();
      test_midframe_next();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
